led_fade_ctrl: RTL and testbench

LED_FADE_CTRL -- requirements
Module: led_fade_ctrl

---
 rtl/led_fade_ctrl.sv | 105 ++++++++++
 tb/tb_led_fade_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/led_fade_ctrl.sv
// LED brightness fader: steps a registered PWM duty toward a commanded target,
// updating only on PWM period boundaries every cmd_periods periods.
module led_fade_ctrl #(
  parameter int PERIOD_LEN = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_target,
  input  logic [7:0] cmd_step,
  input  logic [7:0] cmd_periods,
  input  logic       abort,
  output logic [7:0] duty,
  output logic       busy,
  output logic       done
);

  localparam int PW = (PERIOD_LEN > 1) ? $clog2(PERIOD_LEN) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(PERIOD_LEN - 1);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t            state;
  logic [PW-1:0]     pcnt;
  logic [7:0]        icnt;
  logic [7:0]        target;
  logic [7:0]        step;
  logic [7:0]        periods;
  logic              tick;
  logic [8:0]        up_sum;
  logic signed [8:0] dn_diff;
  logic [7:0]        next_duty;

  assign tick = (pcnt == PCNT_MAX);

  // Widened arithmetic clamps at target instead of wrapping past 255 or below 0.
  always_comb begin
    up_sum    = {1'b0, duty} + {1'b0, step};
    dn_diff   = $signed({1'b0, duty}) - $signed({1'b0, step});
    next_duty = duty;
    if (duty < target)
      next_duty = (up_sum > {1'b0, target}) ? target : up_sum[7:0];
    else if (duty > target)
      next_duty = (dn_diff < $signed({1'b0, target})) ? target : dn_diff[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pcnt      <= '0;
      icnt      <= '0;
      target    <= '0;
      step      <= '0;
      periods   <= '0;
      duty      <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      done <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            target  <= cmd_target;
            step    <= (cmd_step == 8'd0) ? 8'd1 : cmd_step;
            periods <= (cmd_periods == 8'd0) ? 8'd1 : cmd_periods;
            icnt    <= (cmd_periods == 8'd0) ? 8'd1 : cmd_periods;
            if (cmd_target == duty) begin
              done <= 1'b1;
            end else begin
              state     <= RAMP;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end
        RAMP: begin
          if (abort) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else if (tick) begin
            if (icnt > 8'd1) begin
              icnt <= icnt - 8'd1;
            end else begin
              duty <= next_duty;
              icnt <= periods;
              if (next_duty == target) begin
                state     <= IDLE;
                cmd_ready <= 1'b1;
                busy      <= 1'b0;
                done      <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_fade_ctrl.sv
// Self-checking bench for led_fade_ctrl: table of fade commands scored against a
// queue of expected duty steps, plus abort and mid-ramp reset sequences.
module tb_led_fade_ctrl;

  localparam int P = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_target = '0;
  logic [7:0] cmd_step = '0;
  logic [7:0] cmd_periods = '0;
  logic       abort = 1'b0;
  logic [7:0] duty;
  logic       busy;
  logic       done;

  int         checks = 0;
  int         errors = 0;
  int         bcnt;
  logic [7:0] model_duty = '0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] t;
    logic [7:0] s;
    logic [7:0] p;
    int         n;
    logic [7:0] f;
    bit         noise;
  } vec_t;

  vec_t tbl[9];

  led_fade_ctrl #(.PERIOD_LEN(P)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_target(cmd_target), .cmd_step(cmd_step), .cmd_periods(cmd_periods),
    .abort(abort), .duty(duty), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Independent mirror of the free-running period counter.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bcnt <= 0;
    else        bcnt <= (bcnt == P - 1) ? 0 : bcnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic run_cmd(input logic [7:0] t, input logic [7:0] s, input logic [7:0] p,
                         input int exp_n, input logic [7:0] exp_f,
                         input bit with_abort, input bit noise);
    int d, ss, pp, n, gap, budget;
    logic [7:0] prev, e;
    for (int i = 0; i < 4 * P && !cmd_ready; i++) @(negedge clk);
    chk("ready_before_cmd", cmd_ready, 1);
    chk("duty_pre", duty, model_duty);
    ss = (s == 0) ? 1 : int'(s);
    pp = (p == 0) ? 1 : int'(p);
    d  = int'(model_duty);
    while (d != int'(t)) begin
      if (d < int'(t)) d = (d + ss > int'(t)) ? int'(t) : d + ss;
      else             d = (d - ss < int'(t)) ? int'(t) : d - ss;
      exp_q.push_back(8'(d));
    end
    cmd_valid = 1'b1; cmd_target = t; cmd_step = s; cmd_periods = p; abort = with_abort;
    @(posedge clk); #1;
    abort = 1'b0;
    if (noise) begin cmd_target = 8'd77; cmd_step = 8'd3; end
    else cmd_valid = 1'b0;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk("same_done", done, 1);
      chk("same_busy", busy, 0);
      chk("same_duty", duty, model_duty);
      @(negedge clk);
      chk("same_done_pulse", done, 0);
      chk("same_busy2", busy, 0);
      chk("same_n", 0, exp_n);
      return;
    end
    chk("accept_busy", busy, 1);
    chk("accept_done", done, 0);
    chk("accept_ready", cmd_ready, 0);
    n = 0; gap = 0; prev = model_duty;
    budget = (exp_q.size() + 2) * pp * P;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      gap++; budget--;
      if (duty !== prev) begin
        e = exp_q.pop_front();
        chk("step_duty", duty, e);
        chk("tick_align", bcnt, 0);
        if (n > 0) chk("interval", gap, pp * P);
        else       chk("first_interval", (gap > (pp - 1) * P && gap <= pp * P), 1);
        n++; gap = 0; prev = duty; cmd_valid = 1'b0;
        if (exp_q.size() == 0) begin
          chk("end_done", done, 1);
          chk("end_busy", busy, 0);
          chk("end_ready", cmd_ready, 1);
        end else begin
          chk("mid_busy", busy, 1);
          chk("mid_done", done, 0);
        end
      end else begin
        chk("hold_busy", busy, 1);
      end
    end
    if (exp_q.size() > 0) begin
      chk("timeout", 0, 1);
      exp_q.delete();
    end
    cmd_valid = 1'b0;
    chk("update_count", n, exp_n);
    chk("final_duty", duty, exp_f);
    model_duty = exp_f;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{t: 8'd200, s: 8'd50,  p: 8'd1, n: 4, f: 8'd200, noise: 1'b0};
    tbl[1] = '{t: 8'd200, s: 8'd7,   p: 8'd1, n: 0, f: 8'd200, noise: 1'b0};
    tbl[2] = '{t: 8'd0,   s: 8'd255, p: 8'd1, n: 1, f: 8'd0,   noise: 1'b0};
    tbl[3] = '{t: 8'd10,  s: 8'd4,   p: 8'd2, n: 3, f: 8'd10,  noise: 1'b0};
    tbl[4] = '{t: 8'd3,   s: 8'd0,   p: 8'd0, n: 7, f: 8'd3,   noise: 1'b1};
    tbl[5] = '{t: 8'd100, s: 8'd120, p: 8'd1, n: 1, f: 8'd100, noise: 1'b0};
    tbl[6] = '{t: 8'd100, s: 8'd5,   p: 8'd3, n: 0, f: 8'd100, noise: 1'b0};
    tbl[7] = '{t: 8'd255, s: 8'd200, p: 8'd1, n: 1, f: 8'd255, noise: 1'b0};
    tbl[8] = '{t: 8'd250, s: 8'd1,   p: 8'd0, n: 5, f: 8'd250, noise: 1'b0};

    @(negedge clk);
    chk("rst_duty", duty, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);

    for (int i = 0; i < 9; i++)
      run_cmd(tbl[i].t, tbl[i].s, tbl[i].p, tbl[i].n, tbl[i].f, 1'b0, tbl[i].noise);

    // Abort landing on the same edge as a pending duty update.
    for (int i = 0; i < 4 * P && !cmd_ready; i++) @(negedge clk);
    cmd_valid = 1'b1; cmd_target = 8'd0; cmd_step = 8'd10; cmd_periods = 8'd1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 3 * P && duty === model_duty; i++) @(negedge clk);
    chk("abort_first_step", duty, 240);
    for (int i = 0; i < 2 * P && bcnt != P - 1; i++) @(negedge clk);
    chk("abort_pre_tick_duty", duty, 240);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_duty", duty, 240);
    chk("abort_busy", busy, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_done", done, 0);
    @(negedge clk);
    chk("abort_done_next", done, 0);
    chk("abort_duty_next", duty, 240);
    model_duty = 8'd240;
    run_cmd(8'd245, 8'd5, 8'd1, 1, 8'd245, 1'b1, 1'b0);

    // Reset asserted partway through a ramp.
    cmd_valid = 1'b1; cmd_target = 8'd0; cmd_step = 8'd1; cmd_periods = 8'd1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 4 * P && duty !== 8'd243; i++) @(negedge clk);
    chk("pre_reset_duty", duty, 243);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_duty", duty, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_duty = 8'd0;
    @(negedge clk);
    chk("ready_after_rst2", cmd_ready, 1);
    chk("done_after_rst2", done, 0);
    run_cmd(8'd30, 8'd10, 8'd1, 3, 8'd30, 1'b0, 1'b0);

    @(negedge clk);
    chk("final_idle_busy", busy, 0);
    chk("final_hold_duty", duty, model_duty);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
